// File: rtl/rf_write_sched_pkg.sv
// Shared constants and types for the register-file write-port scheduler.
package rf_sched_pkg;

   localparam int unsigned REG_AW = 3;
   localparam int unsigned REG_DW = 8;
   localparam int unsigned NREGS  = 8;

   localparam int unsigned REQ_ALU = 0;
   localparam int unsigned REQ_MEM = 1;
   localparam int unsigned REQ_DBG = 2;

   typedef enum logic [0:0] {
      ARB,
      CLEARING
   } sched_state_e;

endpackage

// File: rtl/rf_write_sched_if.sv
// Writeback-requester bundle: packed per-requester valid/addr/data with one-hot ready.
interface rf_write_sched_if
   import rf_sched_pkg::*;
#(
   parameter int unsigned NREQ = 3
);

   logic [NREQ-1:0]        REQ_VALID;
   logic [REG_AW*NREQ-1:0] REQ_ADDR;
   logic [REG_DW*NREQ-1:0] REQ_DATA;
   logic [NREQ-1:0]        REQ_READY;

   modport master (
      output REQ_VALID,
      output REQ_ADDR,
      output REQ_DATA,
      input  REQ_READY
   );

   modport slave (
      input  REQ_VALID,
      input  REQ_ADDR,
      input  REQ_DATA,
      output REQ_READY
   );

endinterface

// File: rtl/rf_write_sched_rr_arbiter.sv
// One-hot grant from a request vector; round-robin from ptr_i when RF_SCHED_RR_EN
// is defined, otherwise fixed priority with the lowest index winning.
module rf_rr_arbiter #(
   parameter int unsigned NREQ = 3
) (
   input  logic [NREQ-1:0]         req_i,
`ifdef RF_SCHED_RR_EN
   input  logic [$clog2(NREQ)-1:0] ptr_i,
`endif
   output logic [NREQ-1:0]         gnt_o
);

   logic found;

`ifdef RF_SCHED_RR_EN
   // Two passes: indices at/after the pointer first, then wrap to the bottom.
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && req_i[i] && (i >= 32'(ptr_i))) begin
            gnt_o[i] = 1'b1;
            found    = 1'b1;
         end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && req_i[i]) begin
            gnt_o[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end
`else
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!found && req_i[i]) begin
            gnt_o[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/rf_write_sched.sv
// Shares the register file's single write port between NREQ writeback sources and
// sequences a zero-fill CLEAR; RF_SCHED_RR_EN selects round-robin over fixed priority.
module rf_write_sched
   import rf_sched_pkg::*;
#(
   parameter int unsigned NREQ = 3
) (
   input  logic              CLK,
   input  logic              RESET,
   rf_write_sched_if.slave   req_if,
   input  logic              CLEAR,
   output logic              CLEAR_DONE,
   output logic              WRITE,
   output logic [REG_AW-1:0] INADDRESS,
   output logic [REG_DW-1:0] IN,
   output logic [NREGS-1:0]  PENDING
);

   localparam logic [REG_AW-1:0] LAST_REG = REG_AW'(NREGS - 1);

   sched_state_e      state_q, state_d;
   logic [REG_AW-1:0] cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic [REG_AW-1:0] addr_q, addr_d;
   logic [REG_DW-1:0] data_q, data_d;
   logic              done_q, done_d;
   logic [NREQ-1:0]   arb_gnt;
   logic [NREQ-1:0]   gnt;

`ifdef RF_SCHED_RR_EN
   localparam int unsigned PW = $clog2(NREQ);
   logic [PW-1:0] rr_ptr_q, rr_ptr_d;
   logic [PW-1:0] gidx;
`endif

   rf_rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .req_i (req_if.REQ_VALID),
`ifdef RF_SCHED_RR_EN
      .ptr_i (rr_ptr_q),
`endif
      .gnt_o (arb_gnt)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= ARB;
         cnt_q    <= '0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         done_q   <= 1'b0;
`ifdef RF_SCHED_RR_EN
         rr_ptr_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         done_q   <= done_d;
`ifdef RF_SCHED_RR_EN
         rr_ptr_q <= rr_ptr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ARB: begin
            if (CLEAR) begin
               state_d = CLEARING;
               cnt_d   = '0;
            end
         end
         CLEARING: begin
            cnt_d = cnt_q + REG_AW'(1);
            if (cnt_q == LAST_REG) begin
               state_d = ARB;
               cnt_d   = '0;
            end
         end
         default: state_d = ARB;
      endcase
   end

   // Grants are suppressed while clearing, on the CLEAR cycle itself and under reset.
   always_comb begin
      gnt    = (state_q == ARB && !CLEAR && !RESET) ? arb_gnt : '0;
      wr_d   = 1'b0;
      addr_d = addr_q;
      data_d = data_q;
      done_d = 1'b0;
`ifdef RF_SCHED_RR_EN
      rr_ptr_d = rr_ptr_q;
      gidx     = '0;
`endif
      if (state_q == CLEARING) begin
         wr_d   = 1'b1;
         addr_d = cnt_q;
         data_d = '0;
         done_d = (cnt_q == LAST_REG);
      end else begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
               wr_d   = 1'b1;
               addr_d = req_if.REQ_ADDR[i*REG_AW +: REG_AW];
               data_d = req_if.REQ_DATA[i*REG_DW +: REG_DW];
`ifdef RF_SCHED_RR_EN
               gidx   = PW'(i);
`endif
            end
         end
      end
`ifdef RF_SCHED_RR_EN
      if (|gnt) begin
         rr_ptr_d = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
      end
`endif
   end

   assign req_if.REQ_READY = gnt;
   assign WRITE            = wr_q;
   assign INADDRESS        = addr_q;
   assign IN               = data_q;
   assign CLEAR_DONE       = done_q;
   assign PENDING          = wr_q ? (NREGS'(1) << addr_q) : '0;

endmodule
